// File: rtl/gesture_power_module.sv
// Hood gesture power switch: left-then-right powers on, right-then-left powers off, inside a gesture_time window.
// Outputs change on the posedge that samples the triggering key edge; there is no backpressure (level key inputs only).
module gesture_power_module #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int CNT_WIDTH = 27
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       gesture_l,
    input  logic       gesture_r,
    input  logic [3:0] gesture_time,
    output logic       power_on,
    output logic       armed,
    output logic [3:0] remaining
);

    localparam logic [1:0] ST_OFF     = 2'd0;
    localparam logic [1:0] ST_ARM_ON  = 2'd1;
    localparam logic [1:0] ST_ON      = 2'd2;
    localparam logic [1:0] ST_ARM_OFF = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(CLK_FREQ - 1);

    logic [1:0]           state_q, state_d;
    logic                 l_prev_q, r_prev_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]           rem_q, rem_d;
    logic                 power_q, armed_q;

    logic l_rise, r_rise, sec_tick, timeout;

    assign l_rise   = gesture_l & ~l_prev_q;
    assign r_rise   = gesture_r & ~r_prev_q;
    assign sec_tick = (cnt_q == CNT_MAX);
    assign timeout  = sec_tick && (rem_q == 4'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        rem_d   = 4'd0;
        case (state_q)
            ST_OFF: begin
                if (l_rise && !r_rise && gesture_time != 4'd0) begin
                    state_d = ST_ARM_ON;
                    rem_d   = gesture_time;
                end
            end
            ST_ON: begin
                if (r_rise && !l_rise && gesture_time != 4'd0) begin
                    state_d = ST_ARM_OFF;
                    rem_d   = gesture_time;
                end
            end
            default: begin
                // Only the completing key is examined, so completion also wins over timeout.
                if ((state_q == ST_ARM_ON) ? r_rise : l_rise) begin
                    state_d = (state_q == ST_ARM_ON) ? ST_ON : ST_OFF;
                end else if (timeout) begin
                    state_d = (state_q == ST_ARM_ON) ? ST_OFF : ST_ON;
                end else if (sec_tick) begin
                    rem_d = rem_q - 4'd1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    rem_d = rem_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_OFF;
            l_prev_q <= 1'b1;
            r_prev_q <= 1'b1;
            cnt_q    <= '0;
            rem_q    <= 4'd0;
            power_q  <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            l_prev_q <= gesture_l;
            r_prev_q <= gesture_r;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            power_q  <= (state_d == ST_ON) || (state_d == ST_ARM_OFF);
            armed_q  <= (state_d == ST_ARM_ON) || (state_d == ST_ARM_OFF);
        end
    end

    assign power_on  = power_q;
    assign armed     = armed_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_gesture_power_module.sv
// Directed bench for gesture_power_module with CLK_FREQ=10; expectations queued then compared against outputs.
module tb_gesture_power_module;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       gesture_l = 1'b1;
    logic       gesture_r = 1'b1;
    logic [3:0] gesture_time = 4'd5;
    logic       power_on;
    logic       armed;
    logic [3:0] remaining;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic       pwr;
        logic       arm;
        logic [3:0] rem;
    } exp_t;

    exp_t sb[$];

    gesture_power_module #(.CLK_FREQ(10), .CNT_WIDTH(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .gesture_l    (gesture_l),
        .gesture_r    (gesture_r),
        .gesture_time (gesture_time),
        .power_on     (power_on),
        .armed        (armed),
        .remaining    (remaining)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string tag, input logic p, input logic a, input logic [3:0] r);
        exp_t e;
        e.tag = tag;
        e.pwr = p;
        e.arm = a;
        e.rem = r;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d entries required>0", sb.size());
        end else begin
            e = sb.pop_front();
            assert ({power_on, armed, remaining} === {e.pwr, e.arm, e.rem})
            else begin
                errors++;
                $error("FAIL %s observed pwr=%b arm=%b rem=%0d required pwr=%b arm=%b rem=%0d",
                       e.tag, power_on, armed, remaining, e.pwr, e.arm, e.rem);
            end
        end
    endtask

    task automatic check(input string tag, input logic p, input logic a, input logic [3:0] r);
        expect_out(tag, p, a, r);
        compare();
    endtask

    initial begin
        // 1. reset with both keys held high
        tick(3);
        check("in_reset", 1'b0, 1'b0, 4'd0);
        rstn = 1'b1;
        tick(3);
        check("keys_held_through_reset", 1'b0, 1'b0, 4'd0);
        gesture_l = 1'b0;
        gesture_r = 1'b0;
        tick();
        check("keys_released", 1'b0, 1'b0, 4'd0);

        // 2. power on, completion at A+30
        gesture_time = 4'd5;
        gesture_l = 1'b1;
        tick();
        check("on_arm_A", 1'b0, 1'b1, 4'd5);
        gesture_l = 1'b0;
        tick(9);
        check("on_A9", 1'b0, 1'b1, 4'd5);
        tick();
        check("on_A10_step", 1'b0, 1'b1, 4'd4);
        tick(19);
        gesture_r = 1'b1;
        tick();
        check("on_complete_A30", 1'b1, 1'b0, 4'd0);
        gesture_r = 1'b0;
        tick();

        // 5a. power off, completion at B+15
        gesture_time = 4'd2;
        gesture_r = 1'b1;
        tick();
        check("off_arm_B", 1'b1, 1'b1, 4'd2);
        gesture_r = 1'b0;
        tick(14);
        gesture_l = 1'b1;
        tick();
        check("off_complete_B15", 1'b0, 1'b0, 4'd0);
        gesture_l = 1'b0;
        tick();

        // 3. timeout in ARM_ON
        gesture_time = 4'd3;
        gesture_l = 1'b1;
        tick();
        check("to_A", 1'b0, 1'b1, 4'd3);
        gesture_l = 1'b0;
        tick(10);
        check("to_A10", 1'b0, 1'b1, 4'd2);
        tick(10);
        check("to_A20", 1'b0, 1'b1, 4'd1);
        tick(9);
        check("to_A29", 1'b0, 1'b1, 4'd1);
        tick();
        check("to_A30_off", 1'b0, 1'b0, 4'd0);
        gesture_r = 1'b1;
        tick();
        check("to_late_r_A31", 1'b0, 1'b0, 4'd0);
        gesture_r = 1'b0;
        tick();

        // 4a. completion on the timeout posedge wins
        gesture_l = 1'b1;
        tick();
        check("bnd_A", 1'b0, 1'b1, 4'd3);
        gesture_l = 1'b0;
        tick(29);
        gesture_r = 1'b1;
        tick();
        check("bnd_A30_complete", 1'b1, 1'b0, 4'd0);
        gesture_r = 1'b0;
        tick();

        // 5b. ARM_OFF timeout returns to ON
        gesture_time = 4'd2;
        gesture_r = 1'b1;
        tick();
        check("offto_B", 1'b1, 1'b1, 4'd2);
        gesture_r = 1'b0;
        tick(19);
        check("offto_B19", 1'b1, 1'b1, 4'd1);
        tick();
        check("offto_B20_on", 1'b1, 1'b0, 4'd0);

        // quick power off with simultaneous completion in ARM_OFF
        gesture_r = 1'b1;
        tick();
        gesture_r = 1'b0;
        tick();
        gesture_l = 1'b1;
        gesture_r = 1'b1;
        tick();
        check("off_simul_complete", 1'b0, 1'b0, 4'd0);
        gesture_l = 1'b0;
        gesture_r = 1'b0;
        tick();

        // 4b. completion at A+31 is too late
        gesture_time = 4'd3;
        gesture_l = 1'b1;
        tick();
        gesture_l = 1'b0;
        tick(29);
        check("bnd2_A29", 1'b0, 1'b1, 4'd1);
        tick();
        gesture_r = 1'b1;
        tick();
        check("bnd2_A31_late", 1'b0, 1'b0, 4'd0);
        gesture_r = 1'b0;
        tick();

        // 6a. gesture_time=0 disables arming
        gesture_time = 4'd0;
        gesture_l = 1'b1;
        tick();
        check("gt0_no_arm", 1'b0, 1'b0, 4'd0);
        gesture_l = 1'b0;
        tick();

        // 6b. simultaneous keys in OFF do not arm
        gesture_time = 4'd5;
        gesture_l = 1'b1;
        gesture_r = 1'b1;
        tick();
        check("simul_no_arm", 1'b0, 1'b0, 4'd0);
        gesture_l = 1'b0;
        gesture_r = 1'b0;
        tick();

        // 6c. gesture_time change and arming-key re-press mid-window
        gesture_l = 1'b1;
        tick();
        check("chg_A", 1'b0, 1'b1, 4'd5);
        gesture_l = 1'b0;
        gesture_time = 4'd1;
        tick(4);
        gesture_l = 1'b1;
        tick();
        gesture_l = 1'b0;
        tick(5);
        check("chg_A10", 1'b0, 1'b1, 4'd4);
        tick(39);
        check("chg_A49", 1'b0, 1'b1, 4'd1);
        tick();
        check("chg_A50_off", 1'b0, 1'b0, 4'd0);

        // 6d. reset mid-window
        gesture_time = 4'd5;
        gesture_l = 1'b1;
        tick();
        gesture_l = 1'b0;
        tick(6);
        check("rst_pre", 1'b0, 1'b1, 4'd5);
        rstn = 1'b0;
        #1;
        check("rst_async_A7", 1'b0, 1'b0, 4'd0);
        tick(2);
        rstn = 1'b1;
        tick(12);
        check("rst_after", 1'b0, 1'b0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
